// File: rtl/controller_poller_m_if.sv
// Handshake/bus bundle between the controller poller and its neighbours (vblank start source,
// serial controller pins, CPU-visible button registers).
interface controller_poller_m_if;
  logic       start;
  logic       controller_1_data_in_B;
  logic       controller_2_data_in_B;
  logic       controller_clk;
  logic       controller_latch;
  logic [7:0] controller_1_buttons_out;
  logic [7:0] controller_2_buttons_out;
  logic       controller_1_present;
  logic       controller_2_present;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  controller_1_data_in_B,
    input  controller_2_data_in_B,
    output controller_clk,
    output controller_latch,
    output controller_1_buttons_out,
    output controller_2_buttons_out,
    output controller_1_present,
    output controller_2_present,
    output busy,
    output done
  );

  modport slave (
    output start,
    output controller_1_data_in_B,
    output controller_2_data_in_B,
    input  controller_clk,
    input  controller_latch,
    input  controller_1_buttons_out,
    input  controller_2_buttons_out,
    input  controller_1_present,
    input  controller_2_present,
    input  busy,
    input  done
  );
endinterface

// File: rtl/controller_poller_m.sv
// One-shot poller for both serial controller ports: latch, shift 8 (or 9) bits, publish atomically.
// Define CONTROLLER_POLLER_PRESENCE_EN to sample a ninth bit for controller presence detection.
module controller_poller_m #(
  parameter int unsigned LATCH_CYCLES = 2,
  parameter int unsigned HALF_PERIOD  = 2
) (
  input logic                  clk_1,
  input logic                  rst,
  controller_poller_m_if.master bus
);

`ifdef CONTROLLER_POLLER_PRESENCE_EN
  localparam int unsigned NBITS     = 9;
  localparam logic        PresReset = 1'b0;
`else
  localparam int unsigned NBITS     = 8;
  localparam logic        PresReset = 1'b1;
`endif

  localparam int unsigned MaxCyc = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
  localparam int unsigned CW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CW-1:0] LatchLast = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HalfLast  = CW'(HALF_PERIOD - 1);
  localparam logic [3:0]    LastBit   = 4'(NBITS - 1);

  typedef enum logic [1:0] {StIdle, StLatch, StLow, StHigh} state_e;

  state_e           r_state, w_state_next;
  logic [CW-1:0]    r_phase, w_phase_next;
  logic [3:0]       r_bits, w_bits_next;
  logic [NBITS-1:0] r_sh1, r_sh2;
  logic [NBITS-1:0] w_sh1_shift, w_sh2_shift;
  logic             w_shift, w_finish;
  logic             r_clk, r_latch, r_busy, r_done;
  logic [7:0]       r_btn1, r_btn2, w_btn1_next, w_btn2_next;
  logic             r_pres1, r_pres2, w_pres1_next, w_pres2_next;

  // Buttons are active-low on the wire; store them active-high.
  assign w_sh1_shift = {r_sh1[NBITS-2:0], ~bus.controller_1_data_in_B};
  assign w_sh2_shift = {r_sh2[NBITS-2:0], ~bus.controller_2_data_in_B};

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_bits_next  = r_bits;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_phase_next = '0;
        w_bits_next  = '0;
        if (bus.start) w_state_next = StLatch;
      end
      StLatch: begin
        if (r_phase == LatchLast) begin
          w_phase_next = '0;
          w_state_next = StLow;
        end else begin
          w_phase_next = r_phase + CW'(1);
        end
      end
      StLow: begin
        if (r_phase == HalfLast) begin
          w_shift      = 1'b1;
          w_phase_next = '0;
          w_bits_next  = r_bits + 4'd1;
          if (r_bits == LastBit) begin
            w_finish     = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_state_next = StHigh;
          end
        end else begin
          w_phase_next = r_phase + CW'(1);
        end
      end
      StHigh: begin
        if (r_phase == HalfLast) begin
          w_phase_next = '0;
          w_state_next = StLow;
        end else begin
          w_phase_next = r_phase + CW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Values published on the completing edge, taken from the final shifted shadow.
  always_comb begin
`ifdef CONTROLLER_POLLER_PRESENCE_EN
    // A connected controller drives ground after its 8 buttons, i.e. a stored 1 in bit 0.
    w_pres1_next = w_sh1_shift[0];
    w_pres2_next = w_sh2_shift[0];
    w_btn1_next  = w_pres1_next ? w_sh1_shift[8:1] : 8'h00;
    w_btn2_next  = w_pres2_next ? w_sh2_shift[8:1] : 8'h00;
`else
    w_pres1_next = 1'b1;
    w_pres2_next = 1'b1;
    w_btn1_next  = w_sh1_shift[7:0];
    w_btn2_next  = w_sh2_shift[7:0];
`endif
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_phase <= '0;
      r_bits  <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_clk   <= 1'b0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_btn1  <= 8'h00;
      r_btn2  <= 8'h00;
      r_pres1 <= PresReset;
      r_pres2 <= PresReset;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_bits  <= w_bits_next;
      if (w_shift) begin
        r_sh1 <= w_sh1_shift;
        r_sh2 <= w_sh2_shift;
      end
      r_clk   <= (w_state_next == StHigh);
      r_latch <= (w_state_next == StLatch);
      r_busy  <= (w_state_next != StIdle);
      r_done  <= w_finish;
      if (w_finish) begin
        r_btn1  <= w_btn1_next;
        r_btn2  <= w_btn2_next;
        r_pres1 <= w_pres1_next;
        r_pres2 <= w_pres2_next;
      end
    end
  end

  assign bus.controller_clk           = r_clk;
  assign bus.controller_latch         = r_latch;
  assign bus.busy                     = r_busy;
  assign bus.done                     = r_done;
  assign bus.controller_1_buttons_out = r_btn1;
  assign bus.controller_2_buttons_out = r_btn2;
  assign bus.controller_1_present     = r_pres1;
  assign bus.controller_2_present     = r_pres2;

endmodule
